// File: rtl/gate_truth_table_checker_if.sv
// Bus between the gate truth-table checker and the gate it exercises.
// The slave side is the checker; the master side is the gate harness that starts runs and reports dut_out.
interface gate_truth_table_checker_if #(
  parameter int N_IN = 2
);
  logic              start;
  logic [N_IN-1:0]   dut_in;
  logic              dut_out;
  logic              busy;
  logic              done;
  logic              pass;
  logic [N_IN:0]     err_count;
  logic [N_IN-1:0]   first_fail_vec;
  logic              first_fail_vld;

  modport master (
    output start,
    input  dut_in,
    output dut_out,
    input  busy,
    input  done,
    input  pass,
    input  err_count,
    input  first_fail_vec,
    input  first_fail_vld
  );

  modport slave (
    input  start,
    output dut_in,
    input  dut_out,
    output busy,
    output done,
    output pass,
    output err_count,
    output first_fail_vec,
    output first_fail_vld
  );
endinterface

// File: rtl/gate_truth_table_checker.sv
// Walks all 2**N_IN input vectors of a 1-output gate, samples it after a settle window and counts truth-table mismatches.
// Optional first-mismatch capture is enabled by defining GATE_CHECKER_FIRST_FAIL_EN.
module gate_truth_table_checker #(
  parameter int                    N_IN          = 2,
  parameter logic [(2**N_IN)-1:0]  EXPECTED      = 4'b1110,
  parameter int                    SETTLE_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  gate_truth_table_checker_if.slave bus
);

  localparam logic [1:0]      ST_IDLE     = 2'd0;
  localparam logic [1:0]      ST_RUN      = 2'd1;
  localparam logic [1:0]      ST_DONE     = 2'd2;
  localparam logic [3:0]      SETTLE_LAST = 4'(SETTLE_CYCLES);
  localparam logic [N_IN-1:0] VEC_LAST    = '1;

  logic [1:0]      r_state;
  logic [N_IN-1:0] r_vec;
  logic [3:0]      r_settle;
  logic [N_IN:0]   r_err;
  logic            r_pass;

  logic            w_start;
  logic            w_sample;
  logic            w_mismatch;
  logic            w_last_vec;
  logic [N_IN:0]   w_err_next;

  assign w_start    = (r_state == ST_IDLE) && bus.start;
  assign w_sample   = (r_state == ST_RUN) && (r_settle == SETTLE_LAST);
  assign w_mismatch = w_sample && (bus.dut_out != EXPECTED[r_vec]);
  assign w_last_vec = (r_vec == VEC_LAST);
  assign w_err_next = r_err + {{N_IN{1'b0}}, w_mismatch};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_vec    <= '0;
      r_settle <= '0;
      r_err    <= '0;
      r_pass   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state  <= ST_RUN;
            r_vec    <= '0;
            r_settle <= '0;
            r_err    <= '0;
            r_pass   <= 1'b0;
          end
        end
        ST_RUN: begin
          if (w_sample) begin
            r_err    <= w_err_next;
            r_settle <= '0;
            if (w_last_vec) begin
              // pass must already be valid in the single DONE cycle
              r_state <= ST_DONE;
              r_pass  <= (w_err_next == '0);
            end else begin
              r_vec <= r_vec + 1'b1;
            end
          end else begin
            r_settle <= r_settle + 4'd1;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.dut_in    = r_vec;
  assign bus.busy      = (r_state == ST_RUN);
  assign bus.done      = (r_state == ST_DONE);
  assign bus.pass      = r_pass;
  assign bus.err_count = r_err;

`ifdef GATE_CHECKER_FIRST_FAIL_EN
  logic [N_IN-1:0] r_ff_vec;
  logic            r_ff_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ff_vec <= '0;
      r_ff_vld <= 1'b0;
    end else if (w_start) begin
      r_ff_vec <= '0;
      r_ff_vld <= 1'b0;
    end else if (w_mismatch && !r_ff_vld) begin
      r_ff_vec <= r_vec;
      r_ff_vld <= 1'b1;
    end
  end

  assign bus.first_fail_vec = r_ff_vec;
  assign bus.first_fail_vld = r_ff_vld;
`else
  assign bus.first_fail_vec = '0;
  assign bus.first_fail_vld = 1'b0;
`endif

endmodule

// File: tb/tb_gate_truth_table_checker.sv
// Directed bench: a 2-input checker (settle 2) and a 3-input checker (settle 0) driving bench-modelled gates.
module tb_gate_truth_table_checker;

`ifdef GATE_CHECKER_FIRST_FAIL_EN
  localparam bit FF_EN = 1'b1;
`else
  localparam bit FF_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;
  logic [1:0] a_mode;
  logic       b_mode;
  int n_checks;
  int n_errors;

  gate_truth_table_checker_if #(.N_IN(2)) a_if ();
  gate_truth_table_checker_if #(.N_IN(3)) b_if ();

  gate_truth_table_checker #(.N_IN(2), .EXPECTED(4'b1110), .SETTLE_CYCLES(2)) u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (a_if.slave)
  );

  gate_truth_table_checker #(.N_IN(3), .EXPECTED(8'b1111_1110), .SETTLE_CYCLES(0)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b_if.slave)
  );

  // gate models: 0=OR 1=AND 2=NOR 3=XOR
  always_comb begin
    case (a_mode)
      2'd0:    a_if.dut_out = |a_if.dut_in;
      2'd1:    a_if.dut_out = &a_if.dut_in;
      2'd2:    a_if.dut_out = ~|a_if.dut_in;
      default: a_if.dut_out = ^a_if.dut_in;
    endcase
  end

  assign b_if.dut_out = b_mode ? &b_if.dut_in : |b_if.dut_in;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic run_a(input string name, input logic [1:0] mode, input int exp_err,
                       input int exp_ffv, input int repulse_at, input int reset_at);
    int ffv_e;
    int vld_e;
    ffv_e = FF_EN ? exp_ffv : 0;
    vld_e = (FF_EN && exp_err != 0) ? 1 : 0;
    a_mode = mode;
    @(negedge clk);
    a_if.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_if.start = 1'b0;
    check({name, ".clr_err"},  a_if.err_count, 0);
    check({name, ".clr_pass"}, a_if.pass, 0);
    check({name, ".clr_vld"},  a_if.first_fail_vld, 0);
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clk);
      a_if.start = (c + 1 == repulse_at);
      check({name, ".dut_in"}, a_if.dut_in, c / 3);
      check({name, ".busy"},   a_if.busy, 1);
      check({name, ".done"},   a_if.done, 0);
      if (c == reset_at) begin
        check({name, ".err_pre_rst"}, a_if.err_count, 1);
        rst_n = 1'b0;
        #1;
        check({name, ".rst_dut_in"}, a_if.dut_in, 0);
        check({name, ".rst_busy"},   a_if.busy, 0);
        check({name, ".rst_err"},    a_if.err_count, 0);
        check({name, ".rst_pass"},   a_if.pass, 0);
        check({name, ".rst_vld"},    a_if.first_fail_vld, 0);
        check({name, ".rst_ffv"},    a_if.first_fail_vec, 0);
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check({name, ".rst_done"}, a_if.done, 0);
        end
        rst_n = 1'b1;
        $display("run %s: aborted by reset at cycle %0d", name, c);
        return;
      end
    end
    @(negedge clk);
    check({name, ".done"},     a_if.done, 1);
    check({name, ".busy_end"}, a_if.busy, 0);
    check({name, ".pass"},     a_if.pass, (exp_err == 0) ? 1 : 0);
    check({name, ".err"},      a_if.err_count, exp_err);
    check({name, ".ffv"},      a_if.first_fail_vec, ffv_e);
    check({name, ".vld"},      a_if.first_fail_vld, vld_e);
    check({name, ".last_vec"}, a_if.dut_in, 3);
    @(negedge clk);
    check({name, ".done_pulse"}, a_if.done, 0);
    check({name, ".err_hold"},   a_if.err_count, exp_err);
    check({name, ".pass_hold"},  a_if.pass, (exp_err == 0) ? 1 : 0);
    $display("run %s: err_count=%0d pass=%0d first_fail=%0d/%0d",
             name, a_if.err_count, a_if.pass, a_if.first_fail_vld, a_if.first_fail_vec);
  endtask

  task automatic run_b(input string name, input logic mode, input int exp_err, input int exp_ffv);
    int ffv_e;
    int vld_e;
    ffv_e = FF_EN ? exp_ffv : 0;
    vld_e = (FF_EN && exp_err != 0) ? 1 : 0;
    b_mode = mode;
    @(negedge clk);
    b_if.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b_if.start = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) @(negedge clk);
      check({name, ".dut_in"}, b_if.dut_in, c);
      check({name, ".done"},   b_if.done, 0);
    end
    @(negedge clk);
    check({name, ".done"}, b_if.done, 1);
    check({name, ".pass"}, b_if.pass, (exp_err == 0) ? 1 : 0);
    check({name, ".err"},  b_if.err_count, exp_err);
    check({name, ".ffv"},  b_if.first_fail_vec, ffv_e);
    check({name, ".vld"},  b_if.first_fail_vld, vld_e);
    $display("run %s: err_count=%0d pass=%0d first_fail=%0d/%0d",
             name, b_if.err_count, b_if.pass, b_if.first_fail_vld, b_if.first_fail_vec);
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    rst_n      = 1'b0;
    a_if.start = 1'b0;
    b_if.start = 1'b0;
    a_mode     = 2'd0;
    b_mode     = 1'b0;
    repeat (3) @(negedge clk);
    check("reset.dut_in", a_if.dut_in, 0);
    check("reset.busy",   a_if.busy, 0);
    check("reset.done",   a_if.done, 0);
    check("reset.pass",   a_if.pass, 0);
    check("reset.err",    a_if.err_count, 0);
    check("reset.ffv",    a_if.first_fail_vec, 0);
    check("reset.vld",    a_if.first_fail_vld, 0);
    check("reset.b_busy", b_if.busy, 0);
    rst_n = 1'b1;
    @(negedge clk);
    $display("reset: outputs idle");

    // AND vs OR table differs at vectors 1 and 2; XOR differs only at 3; NOR differs everywhere
    run_a("or",         2'd0, 0, 0, -1, -1);
    run_a("and",        2'd1, 2, 1, -1, -1);
    run_a("or_repulse", 2'd0, 0, 0,  4, -1);
    run_a("xor",        2'd3, 1, 3, -1, -1);
    run_a("nor_max",    2'd2, 4, 0, -1, -1);
    run_a("nor_reset",  2'd2, 0, 0, -1,  5);
    run_a("or_clean",   2'd0, 0, 0, -1, -1);

    run_b("or3",  1'b0, 0, 0);
    run_b("and3", 1'b1, 6, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
